// File: rtl/burst_store_pkg.sv
// Shared types and default sizing for the burst sample store.
package burst_store_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_WRITE
  } state_t;

  localparam int DEF_SAMPLE_W  = 24;
  localparam int DEF_MAX_BURST = 32;
  localparam int DEF_NUM_W     = 6;
  localparam int DEF_DEPTH     = 3750;
  localparam int DROP_CNT_W    = 16;

endpackage

// File: rtl/sample_store_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, read-first.
module sample_store_ram #(
  parameter int W      = 24,
  parameter int DEPTH  = 3750,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data
);

  logic [W-1:0] mem [DEPTH];

  // No reset on the array or read register so the tools can map this onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/burst_sample_store.sv
// Unpacks data_ready-qualified bursts into a DEPTH-deep store, one sample per cycle, with registered readback.
// Optional BURST_STORE_DROP_CNT_EN adds a saturating drop_count output.
module burst_sample_store
  import burst_store_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int NUM_W     = DEF_NUM_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_ready,
  input  logic [NUM_W-1:0]              num_samples,
  input  logic [MAX_BURST*SAMPLE_W-1:0] fifo_data,
  input  logic                          wrap_en,
  input  logic                          clear,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [SAMPLE_W-1:0]           rd_data,
  output logic                          rd_valid,
  output logic                          busy,
  output logic                          burst_done,
  output logic [CNT_W-1:0]              count,
  output logic [ADDR_W-1:0]             last_index,
  output logic                          full,
  output logic                          overrun
`ifdef BURST_STORE_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]         drop_count
`endif
);

  localparam int N_W   = $clog2(MAX_BURST + 1);
  localparam int IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  state_t                        state_q, state_d;
  logic [MAX_BURST*SAMPLE_W-1:0] burst_q;
  logic [N_W-1:0]                n_q, n_in;
  logic [IDX_W-1:0]              idx_q;
  logic [ADDR_W-1:0]             wr_ptr;
  logic                          start, last, wr_act, we, rd_oob, rd_zero_q;
  logic [SAMPLE_W-1:0]           wr_sample, ram_q;

  assign busy      = (state_q == ST_WRITE);
  assign we        = wr_act && (!full || wrap_en);
  assign wr_sample = burst_q[32'(idx_q) * SAMPLE_W +: SAMPLE_W];
  assign rd_oob    = {1'b0, rd_addr} >= (ADDR_W + 1)'(DEPTH);
  assign rd_data   = rd_zero_q ? '0 : ram_q;

  always_comb begin
    n_in    = (32'(num_samples) > MAX_BURST) ? N_W'(MAX_BURST) : N_W'(num_samples);
    start   = 1'b0;
    last    = 1'b0;
    wr_act  = 1'b0;
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (data_ready && num_samples != '0) begin
          start   = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_act = 1'b1;
        last   = (N_W'(idx_q) == n_q - N_W'(1));
        if (last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Clear aborts everything in flight, including the completion pulse.
    if (clear) begin
      start   = 1'b0;
      last    = 1'b0;
      wr_act  = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (start) burst_q <= fifo_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q        <= '0;
      idx_q      <= '0;
      burst_done <= 1'b0;
      wr_ptr     <= '0;
      count      <= '0;
      last_index <= '0;
      full       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      burst_done <= last;
      if (clear) begin
        idx_q      <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        last_index <= '0;
        full       <= 1'b0;
        overrun    <= 1'b0;
      end else begin
        if (start) begin
          n_q   <= n_in;
          idx_q <= '0;
        end else if (wr_act) begin
          idx_q <= idx_q + IDX_W'(1);
        end
        if (busy && data_ready) overrun <= 1'b1;
        if (we) begin
          last_index <= wr_ptr;
          wr_ptr     <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + ADDR_W'(1);
          if (!full) begin
            count <= count + CNT_W'(1);
            full  <= (count == CNT_W'(DEPTH - 1));
          end
        end
      end
    end
  end

  // rd_zero_q starts set so rd_data reads 0 out of reset, and masks out-of-range reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid  <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_zero_q <= rd_oob;
    end
  end

  sample_store_ram #(
    .W      (SAMPLE_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (wr_sample),
    .re      (rd_en && !rd_oob),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

`ifdef BURST_STORE_DROP_CNT_EN
  logic [DROP_CNT_W:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_count}
             + (DROP_CNT_W + 1)'(wr_act && full && !wrap_en)
             + ((busy && data_ready) ? (DROP_CNT_W + 1)'(n_in) : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      drop_count <= '0;
    else if (clear) drop_count <= '0;
    else            drop_count <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_burst_sample_store.sv
// Directed bench for burst_sample_store: DEPTH=8/MAX_BURST=4/SAMPLE_W=8, plus a DEPTH=5 copy for out-of-range reads.
module tb_burst_sample_store;

  logic        clk = 1'b0;
  logic        reset, data_ready, wrap_en, clear, rd_en;
  logic [3:0]  num_samples;
  logic [31:0] fifo_data;
  logic [2:0]  rd_addr;

  logic [7:0]  rd_data, rd_data2;
  logic        rd_valid, rd_valid2, busy, busy2, burst_done, burst_done2;
  logic        full, full2, overrun, overrun2;
  logic [3:0]  count;
  logic [2:0]  count2;
  logic [2:0]  last_index, last_index2;
`ifdef BURST_STORE_DROP_CNT_EN
  logic [15:0] drop_count, drop_count2;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;

  localparam logic [31:0] B1 = 32'h1413_1211;
  localparam logic [31:0] B2 = 32'h2423_2221;
  localparam logic [31:0] B3 = 32'h3433_3231;

  always #5 clk = ~clk;

  burst_sample_store #(.SAMPLE_W(8), .MAX_BURST(4), .NUM_W(4), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .data_ready(data_ready), .num_samples(num_samples),
    .fifo_data(fifo_data), .wrap_en(wrap_en), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .burst_done(burst_done),
    .count(count), .last_index(last_index), .full(full), .overrun(overrun)
`ifdef BURST_STORE_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  burst_sample_store #(.SAMPLE_W(8), .MAX_BURST(4), .NUM_W(4), .DEPTH(5)) dut5 (
    .clk(clk), .reset(reset), .data_ready(data_ready), .num_samples(num_samples),
    .fifo_data(fifo_data), .wrap_en(wrap_en), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2), .burst_done(burst_done2),
    .count(count2), .last_index(last_index2), .full(full2), .overrun(overrun2)
`ifdef BURST_STORE_DROP_CNT_EN
    , .drop_count(drop_count2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] n, input logic [31:0] d);
    data_ready  = 1'b1;
    num_samples = n;
    fifo_data   = d;
    tick();
    data_ready  = 1'b0;
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (busy && c < 20) begin
      tick();
      c++;
    end
    check("busy_release", {31'd0, busy}, 32'd0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
    check(tag, {24'd0, rd_data}, {24'd0, exp});
    check({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; data_ready = 1'b0; num_samples = '0; fifo_data = '0;
    wrap_en = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_flags", {29'd0, burst_done, full, overrun}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic 3-sample burst: one write per cycle, done pulse four cycles after data_ready.
    send(4'd3, 32'h0033_2211);
    check("a_busy", {31'd0, busy}, 32'd1);
    check("a_cnt0", {28'd0, count}, 32'd0);
    tick();
    check("a_cnt1", {28'd0, count}, 32'd1);
    tick();
    check("a_cnt2", {28'd0, count}, 32'd2);
    check("a_done_early", {31'd0, burst_done}, 32'd0);
    tick();
    check("a_cnt3", {28'd0, count}, 32'd3);
    check("a_last", {29'd0, last_index}, 32'd2);
    check("a_busy_low", {31'd0, busy}, 32'd0);
    check("a_done", {31'd0, burst_done}, 32'd1);
    tick();
    check("a_done_pulse", {31'd0, burst_done}, 32'd0);
    rd(3'd0, 8'h11, "a_rd0");
    rd(3'd1, 8'h22, "a_rd1");
    rd(3'd2, 8'h33, "a_rd2");
    tick();
    check("a_rd_idle_vld", {31'd0, rd_valid}, 32'd0);
    check("a_rd_hold", {24'd0, rd_data}, 32'h33);

    // Stop-when-full.
    do_clear();
    check("clr_count", {28'd0, count}, 32'd0);
    wrap_en = 1'b0;
    send(4'd4, B1); wait_idle(cyc);
    check("s_cyc", cyc, 32'd4);
    check("s_cnt4", {28'd0, count}, 32'd4);
    check("s_full0", {31'd0, full}, 32'd0);
    send(4'd4, B2); wait_idle(cyc);
    check("s_cnt8", {28'd0, count}, 32'd8);
    check("s_full1", {31'd0, full}, 32'd1);
    send(4'd4, B3); wait_idle(cyc);
    check("s_cnt_sat", {28'd0, count}, 32'd8);
    check("s_last", {29'd0, last_index}, 32'd7);
`ifdef BURST_STORE_DROP_CNT_EN
    check("s_drop", {16'd0, drop_count}, 32'd4);
`endif
    rd(3'd0, 8'h11, "s_rd0");
    rd(3'd3, 8'h14, "s_rd3");
    rd(3'd7, 8'h24, "s_rd7");

    // Ring mode: third burst overwrites the oldest samples.
    do_clear();
    wrap_en = 1'b1;
    send(4'd4, B1); wait_idle(cyc);
    send(4'd4, B2); wait_idle(cyc);
    send(4'd4, B3); wait_idle(cyc);
    check("w_cnt", {28'd0, count}, 32'd8);
    check("w_full", {31'd0, full}, 32'd1);
    check("w_last", {29'd0, last_index}, 32'd3);
`ifdef BURST_STORE_DROP_CNT_EN
    check("w_drop", {16'd0, drop_count}, 32'd0);
`endif
    rd(3'd0, 8'h31, "w_rd0");
    rd(3'd3, 8'h34, "w_rd3");
    rd(3'd4, 8'h21, "w_rd4");

    // Overrun: second burst one cycle into the first is discarded.
    do_clear();
    wrap_en = 1'b0;
    send(4'd4, B1);
    send(4'd4, B3);
    wait_idle(cyc);
    check("o_overrun", {31'd0, overrun}, 32'd1);
    check("o_cnt", {28'd0, count}, 32'd4);
    check("o_last", {29'd0, last_index}, 32'd3);
`ifdef BURST_STORE_DROP_CNT_EN
    check("o_drop", {16'd0, drop_count}, 32'd4);
`endif
    rd(3'd3, 8'h14, "o_rd3");

    // Clear two cycles into a burst.
    do_clear();
    check("c_overrun_clr", {31'd0, overrun}, 32'd0);
    send(4'd4, B2);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("c_cnt", {28'd0, count}, 32'd0);
    check("c_last", {29'd0, last_index}, 32'd0);
    check("c_busy", {31'd0, busy}, 32'd0);
    check("c_done0", {31'd0, burst_done}, 32'd0);
    tick();
    check("c_done1", {31'd0, burst_done}, 32'd0);
    send(4'd1, 32'h0000_00AA); wait_idle(cyc);
    check("c_cnt1", {28'd0, count}, 32'd1);
    check("c_last1", {29'd0, last_index}, 32'd0);
    rd(3'd0, 8'hAA, "c_rd0");

    // num_samples==0 is ignored.
    send(4'd0, 32'hDEAD_BEEF);
    check("z_busy", {31'd0, busy}, 32'd0);
    tick();
    check("z_done", {31'd0, burst_done}, 32'd0);
    check("z_cnt", {28'd0, count}, 32'd1);

    // num_samples=9 clamps to 4 writes.
    send(4'd9, 32'h4443_4241); wait_idle(cyc);
    check("m_cyc", cyc, 32'd4);
    check("m_cnt", {28'd0, count}, 32'd5);
    check("m_last", {29'd0, last_index}, 32'd4);
    rd(3'd1, 8'h41, "m_rd1");
    rd(3'd4, 8'h44, "m_rd4");
    check("m_rd1_d5", {24'd0, rd_data2}, 32'h44);

    // Out-of-range read on the DEPTH=5 copy returns 0 but is still valid.
    rd(3'd6, 8'h23, "x_rd6");
    check("x_oob_data", {24'd0, rd_data2}, 32'd0);
    check("x_oob_vld", {31'd0, rd_valid2}, 32'd1);

    // Reset asserted mid-burst aborts immediately.
    send(4'd4, B1);
    tick();
    reset = 1'b1;
    #1;
    check("r_busy", {31'd0, busy}, 32'd0);
    check("r_cnt", {28'd0, count}, 32'd0);
    check("r_last", {29'd0, last_index}, 32'd0);
    check("r_rd_data", {24'd0, rd_data}, 32'd0);
    #2;
    reset = 1'b0;
    tick();
    tick();
    check("r_cnt_after", {28'd0, count}, 32'd0);
    check("r_done_after", {31'd0, burst_done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
